// File: rtl/z16_pkg.sv
// ----------------------------------------------------------------------------
// z16_pkg
// Shared definitions for the Z16 front end: datapath widths, the fetch FSM
// state encoding and the fetch-entry record handed from fetch to decode.
// ----------------------------------------------------------------------------
package z16_pkg;

    localparam int Z16_XLEN    = 16;
    localparam int Z16_INSTR_W = 16;
    localparam int Z16_PC_STEP = 2;

    // Fetch sequencer states.
    //   FETCH_IDLE  : single settling cycle after reset release, no request
    //   FETCH_RUN   : normal streaming of instruction reads
    //   FETCH_DRAIN : waiting out a request that a redirect made stale
    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_RUN,
        FETCH_DRAIN
    } fetch_state_t;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [Z16_INSTR_W-1:0] instr;
        logic [Z16_XLEN-1:0]    pc;
    } fetch_entry_t;

    // Instructions are halfword aligned: bit 0 of any target is cleared.
    function automatic logic [Z16_XLEN-1:0] z16_align_pc(input logic [Z16_XLEN-1:0] addr);
        return addr & ~Z16_XLEN'(1);
    endfunction

endpackage

// File: rtl/z16_fetch_fifo.sv
// ----------------------------------------------------------------------------
// z16_fetch_fifo
// Small synchronous FIFO of fetch entries sitting between the instruction
// memory interface and the decoder. The head entry is presented
// combinationally so a word pushed in cycle t is visible in cycle t+1.
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   push       : write push_data at the tail (ignored when full)
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty)
//   flush      : discard all entries; wins over push and pop
//   head       : head entry, all-zero while empty
//   count      : number of stored entries (0..DEPTH)
//   full       : count == DEPTH
//   empty      : count == 0
// ----------------------------------------------------------------------------
module z16_fetch_fifo
    import z16_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    fetch_entry_t     mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;

    logic do_push;
    logic do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset; the head mux below hides stale contents so
    // the outputs are defined zeros whenever nothing is buffered.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && !flush && (wr_ptr_reg == PTR_W'(gi))) begin
                mem_reg[gi] <= push_data;
            end
        end
    end

    assign head = empty ? '0 : mem_reg[rd_ptr_reg];

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/z16_fetch_unit.sv
// ----------------------------------------------------------------------------
// z16_fetch_unit
// Instruction fetch stage of the Z16 core. Owns the PC, streams 16-bit reads
// to instruction memory over a req/ack handshake, buffers returned words in a
// prefetch FIFO and hands {instr, pc} to the decoder with valid/ready.
// A redirect from execute flushes buffered words and restarts fetch at the
// (halfword aligned) target; a request already on the bus when the redirect
// arrives is completed and its data thrown away.
//
// Ports
//   i_clk          : clock, rising edge
//   i_rst_n        : asynchronous active-low reset
//   o_imem_req     : fetch request
//   o_imem_addr    : fetch address, held while a request is unacknowledged
//   i_imem_ack     : memory accepts the request, i_imem_rdata valid
//   i_imem_rdata   : instruction word
//   i_redirect     : one-cycle pulse, restart fetch at i_redirect_pc
//   i_redirect_pc  : redirect target (bit 0 forced to zero)
//   o_instr_valid  : FIFO head valid
//   o_instr        : FIFO head instruction
//   o_instr_pc     : address of o_instr
//   i_instr_ready  : decoder takes the head when valid & ready
// ----------------------------------------------------------------------------
module z16_fetch_unit
    import z16_pkg::*;
#(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [15:0] PC_STEP    = 16'd2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [15:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [15:0] i_imem_rdata,
    input  logic        i_redirect,
    input  logic [15:0] i_redirect_pc,
    output logic        o_instr_valid,
    output logic [15:0] o_instr,
    output logic [15:0] o_instr_pc,
    input  logic        i_instr_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t        state_reg;
    logic [15:0]         pc_reg;
    logic [15:0]         drain_addr_reg;

    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    fetch_entry_t        fifo_head;
    fetch_entry_t        fifo_push_data;

    logic                ack_take;
    logic                fifo_push;
    logic                fifo_pop;
    logic [15:0]         redirect_target;

    // Request and address depend only on state and occupancy registers, so
    // neither ready nor redirect has a combinational path onto the bus. A
    // full FIFO keeps req low for the cycle of a pop: one bubble, by design.
    assign o_imem_req  = (state_reg == FETCH_DRAIN) ||
                         ((state_reg == FETCH_RUN) && (fifo_count < CNT_W'(FIFO_DEPTH)));

    // While draining, the stale request keeps its original address on the bus
    // even though pc_reg already points at the redirect target.
    assign o_imem_addr = (state_reg == FETCH_DRAIN) ? drain_addr_reg : pc_reg;

    assign ack_take        = o_imem_req && i_imem_ack;
    assign redirect_target = z16_align_pc(i_redirect_pc);

    // Only words fetched on the live stream are kept; a word returning in the
    // same cycle as a redirect belongs to the old stream and is dropped.
    assign fifo_push      = (state_reg == FETCH_RUN) && ack_take && !i_redirect && !fifo_full;
    assign fifo_pop       = i_instr_ready && !fifo_empty;
    assign fifo_push_data = '{instr: i_imem_rdata, pc: pc_reg};

    z16_fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (fifo_push),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .flush     (i_redirect),
        .head      (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign o_instr_valid = !fifo_empty;
    assign o_instr       = fifo_head.instr;
    assign o_instr_pc    = fifo_head.pc;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= FETCH_IDLE;
            pc_reg         <= RESET_PC;
            drain_addr_reg <= '0;
        end else begin
            case (state_reg)
                FETCH_IDLE: begin
                    state_reg <= FETCH_RUN;
                    if (i_redirect) begin
                        pc_reg <= redirect_target;
                    end
                end

                FETCH_RUN: begin
                    if (i_redirect) begin
                        pc_reg <= redirect_target;
                        // An unacknowledged request cannot be withdrawn;
                        // park its address and wait for the ack.
                        if (o_imem_req && !i_imem_ack) begin
                            drain_addr_reg <= pc_reg;
                            state_reg      <= FETCH_DRAIN;
                        end
                    end else if (ack_take) begin
                        pc_reg <= pc_reg + PC_STEP;
                    end
                end

                FETCH_DRAIN: begin
                    // Later redirects only retarget; the stale request
                    // still has to finish before fetching resumes.
                    if (i_redirect) begin
                        pc_reg <= redirect_target;
                    end
                    if (i_imem_ack) begin
                        state_reg <= FETCH_RUN;
                    end
                end

                default: begin
                    state_reg <= FETCH_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_z16_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_z16_fetch_unit
// Randomized bench for the Z16 fetch stage. A memory responder acks requests
// after a configurable latency; a reference model tracks the expected fetch
// stream as a queue of {instr, pc}; a monitor pops that queue whenever the
// decoder side takes an instruction and compares.
// ----------------------------------------------------------------------------
module tb_z16_fetch_unit;

    localparam int          DEPTH  = 2;
    localparam logic [15:0] RST_PC = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ack = 1'b0;
    logic [15:0] rdata = 16'h0000;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        ready = 1'b0;

    logic        imem_req;
    logic [15:0] imem_addr;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;

    always #5 clk = ~clk;

    z16_fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH),
        .PC_STEP    (16'd2)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_ack    (ack),
        .i_imem_rdata  (rdata),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .o_instr_valid (instr_valid),
        .o_instr       (instr),
        .o_instr_pc    (instr_pc),
        .i_instr_ready (ready)
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [15:0] memf(input logic [15:0] a);
        logic [15:0] p;
        p = a * 16'd40503;
        return p ^ 16'h5A3C;
    endfunction

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [15:0] q_instr[$];
    logic [15:0] q_pc[$];
    logic [15:0] m_pc;
    logic [15:0] m_drain_addr;
    bit          m_idle;
    bit          m_draining;
    bit          m_exp_req;
    bit          c_ack;
    bit          c_redir;
    logic [15:0] c_rpc;

    task automatic model_reset();
        q_instr.delete();
        q_pc.delete();
        m_pc         = RST_PC;
        m_drain_addr = 16'h0000;
        m_idle       = 1'b1;
        m_draining   = 1'b0;
        m_exp_req    = 1'b0;
        c_ack        = 1'b0;
        c_redir      = 1'b0;
        c_rpc        = 16'h0000;
    endtask

    // Bus checks and capture of this cycle's events (inputs are stable here).
    always @(negedge clk) begin
        if (rst_n) begin
            chk("imem_req", imem_req, m_exp_req);
            if (m_exp_req) begin
                chk("imem_addr", imem_addr, m_draining ? m_drain_addr : m_pc);
            end
            c_ack   = ack;
            c_redir = redirect;
            c_rpc   = redirect_pc;
        end
    end

    // Advance the model with the events of the cycle that just ended.
    always @(posedge clk) begin
        if (rst_n) begin
            logic [15:0] tgt;
            bit          take;
            tgt  = {c_rpc[15:1], 1'b0};
            take = m_exp_req && c_ack;
            if (m_idle) begin
                m_idle = 1'b0;
                if (c_redir) m_pc = tgt;
            end else if (m_draining) begin
                if (c_redir) begin
                    m_pc = tgt;
                    q_instr.delete();
                    q_pc.delete();
                end
                if (take) m_draining = 1'b0;
            end else begin
                if (c_redir) begin
                    q_instr.delete();
                    q_pc.delete();
                    if (m_exp_req && !c_ack) begin
                        m_draining   = 1'b1;
                        m_drain_addr = m_pc;
                    end
                    m_pc = tgt;
                end else if (take) begin
                    q_instr.push_back(memf(m_pc));
                    q_pc.push_back(m_pc);
                    m_pc = m_pc + 16'd2;
                end
            end
            m_exp_req = !m_idle && (m_draining || (q_pc.size() < DEPTH));
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            chk("instr_valid", instr_valid, q_pc.size() > 0);
            if (instr_valid && ready && !redirect) begin
                if (q_pc.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_instr: got pc=%h instr=%h, expected nothing", instr_pc, instr);
                end else begin
                    logic [15:0] e_instr;
                    logic [15:0] e_pc;
                    e_instr = q_instr.pop_front();
                    e_pc    = q_pc.pop_front();
                    chk("instr", instr, e_instr);
                    chk("instr_pc", instr_pc, e_pc);
                    $display("deliver pc=%h instr=%h (expected pc=%h instr=%h)", instr_pc, instr, e_pc, e_instr);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    int lat_cfg = 0;      // -1 selects a random latency per request
    int cur_lat = 0;
    int wait_cnt = 0;
    bit rand_ready = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
        redirect = 1'b0;
        if (imem_req && (wait_cnt >= cur_lat)) begin
            ack   = 1'b1;
            rdata = memf(imem_addr);
        end else begin
            ack   = 1'b0;
            rdata = 16'($urandom);
        end
        if (imem_req && ack) begin
            wait_cnt = 0;
            cur_lat  = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
        end else if (imem_req) begin
            wait_cnt++;
        end
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        bit found;
        model_reset();
        ready = 1'b1;

        // Reset values
        #2;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_instr_pc", instr_pc, 16'h0000);
        #21 rst_n = 1'b1;

        // Streaming with ack and ready tied high
        repeat (30) step();

        // Decoder stalls: FIFO fills, request drops
        ready = 1'b0;
        repeat (8) step();
        chk("full_req_low", imem_req, 1'b0);
        chk("full_valid", instr_valid, 1'b1);
        ready = 1'b1;
        repeat (10) step();

        // Fixed 3-cycle memory latency, random decoder stalls
        lat_cfg    = 3;
        cur_lat    = 3;
        rand_ready = 1'b1;
        repeat (40) step();

        // Redirect while a request waits for its ack
        rand_ready = 1'b0;
        ready      = 1'b1;
        found      = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (imem_req && !ack) begin
                redirect    = 1'b1;
                redirect_pc = 16'h0041;
                found       = 1'b1;
                break;
            end
        end
        chk("drain_window", found, 1'b1);
        repeat (20) step();

        // Redirect coinciding with an ack and a pop
        lat_cfg = 0;
        cur_lat = 0;
        ready   = 1'b0;
        found   = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if ((q_pc.size() == 1) && imem_req && ack) begin
                ready       = 1'b1;
                redirect    = 1'b1;
                redirect_pc = 16'($urandom);
                found       = 1'b1;
                break;
            end
        end
        chk("ack_pop_redirect_window", found, 1'b1);
        repeat (10) step();

        // Random latency, stalls and redirects
        lat_cfg    = -1;
        rand_ready = 1'b1;
        repeat (400) begin
            step();
            if ($urandom_range(0, 19) == 0) begin
                redirect    = 1'b1;
                redirect_pc = 16'($urandom);
            end
        end

        // Asynchronous reset while a request waits and the FIFO holds data
        rand_ready = 1'b0;
        ready      = 1'b0;
        lat_cfg    = 5;
        found      = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (instr_valid && imem_req && !ack && (wait_cnt > 1)) begin
                found = 1'b1;
                break;
            end
        end
        chk("async_reset_window", found, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", imem_req, 1'b0);
        chk("arst_valid", instr_valid, 1'b0);
        chk("arst_instr", instr, 16'h0000);
        chk("arst_instr_pc", instr_pc, 16'h0000);
        model_reset();
        ack      = 1'b0;
        wait_cnt = 0;
        lat_cfg  = 0;
        cur_lat  = 0;
        ready    = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (imem_req) begin
                found = 1'b1;
                break;
            end
        end
        chk("req_after_reset", found, 1'b1);
        chk("first_addr_after_reset", imem_addr, RST_PC);
        repeat (20) step();

        redirect = 1'b0;
        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
